// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, register word type and the
// read-port FSM state encoding used by register_file.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef logic [XLEN-1:0] reg_word;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage : core_pkg

// File: rtl/register_file_regbank.sv
// regbank: 32 x 32-bit register array, one synchronous write port and three
// asynchronous read ports. ZERO_R0=1 hard-wires entry 0 to zero and drops
// writes to it (integer file); ZERO_R0=0 makes entry 0 ordinary (float file).
module regbank
    import core_pkg::*;
#(
    parameter logic ZERO_R0 = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    input  logic [REG_IDX_W-1:0] raddr3,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2,
    output logic [XLEN-1:0]      rdata3
);

    reg_word mem_q [NUM_REGS];
    reg_word mem_d [NUM_REGS];

    // Read one entry, forcing entry 0 to zero on the hard-wired bank.
    function automatic reg_word read_entry(input logic [REG_IDX_W-1:0] idx,
                                           input reg_word             val);
        reg_word r;
        if (ZERO_R0 && (idx == REG_ZERO)) begin
            r = {XLEN{1'b0}};
        end else begin
            r = val;
        end
        return r;
    endfunction

    // Next-state of the array: apply the single write unless it targets a hard-wired zero.
    always_comb begin
        mem_d = mem_q;
        if (we && !(ZERO_R0 && (waddr == REG_ZERO))) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Array storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read ports reflect the committed (pre-write) array contents.
    always_comb begin
        rdata1 = read_entry(raddr1, mem_q[raddr1]);
        rdata2 = read_entry(raddr2, mem_q[raddr2]);
        rdata3 = read_entry(raddr3, mem_q[raddr3]);
    end

endmodule : regbank

// File: rtl/register_file.sv
// register_file: integer and float register banks, program counter, and a
// one-cycle-latency three-operand read port with a done pulse.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to a
// matching read operand; left undefined, such a read returns the old value.
module register_file
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wenable,
    input  logic        fmode,
    input  logic [4:0]  wreg,
    input  logic [31:0] wdata,
    input  logic        pcenable,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    input  logic        enable,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rs3,
    input  logic [2:0]  rs_fmode,
    output logic        done,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] rdata3
);

    logic [REG_IDX_W-1:0] rs_idx_s [3];
    reg_word              int_rd_s [3];
    reg_word              flt_rd_s [3];
    reg_word              operand_s [3];

    rd_state_e state_q, state_d;
    reg_word   rdata_q [3];
    reg_word   rdata_d [3];
    reg_word   pc_q, pc_d;

    logic int_we_s;
    logic flt_we_s;

    assign rs_idx_s[0] = rs1;
    assign rs_idx_s[1] = rs2;
    assign rs_idx_s[2] = rs3;

    assign int_we_s = wenable & ~fmode;
    assign flt_we_s = wenable &  fmode;

    regbank #(.ZERO_R0(1'b1)) u_int_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (int_we_s),
        .waddr  (wreg),
        .wdata  (wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .raddr3 (rs3),
        .rdata1 (int_rd_s[0]),
        .rdata2 (int_rd_s[1]),
        .rdata3 (int_rd_s[2])
    );

    regbank #(.ZERO_R0(1'b0)) u_flt_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (flt_we_s),
        .waddr  (wreg),
        .wdata  (wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .raddr3 (rs3),
        .rdata1 (flt_rd_s[0]),
        .rdata2 (flt_rd_s[1]),
        .rdata3 (flt_rd_s[2])
    );

    // Per-operand bank select, with optional forwarding of the in-flight write.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (rs_fmode[i]) begin
                operand_s[i] = flt_rd_s[i];
            end else begin
                operand_s[i] = int_rd_s[i];
            end
`ifdef REGFILE_BYPASS_EN
            // Integer x0 never forwards: its write is discarded.
            if (wenable && (fmode == rs_fmode[i]) && (wreg == rs_idx_s[i]) &&
                (fmode || (wreg != REG_ZERO))) begin
                operand_s[i] = wdata;
            end else begin
                operand_s[i] = operand_s[i];
            end
`endif
        end
    end

    // Read FSM and pc next-state: accept a read whenever enable is high, else hold results.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        if (enable) begin
            state_d = RD_RESP;
            rdata_d = operand_s;
        end else begin
            state_d = RD_IDLE;
            rdata_d = rdata_q;
        end
        if (pcenable) begin
            pc_d = next_pc;
        end else begin
            pc_d = pc_q;
        end
    end

    // Read FSM state, registered read results and pc; reset discards any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            pc_q    <= RESET_PC;
            for (int i = 0; i < 3; i++) begin
                rdata_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
        end
    end

    assign done   = (state_q == RD_RESP);
    assign pc     = pc_q;
    assign rdata1 = rdata_q[0];
    assign rdata2 = rdata_q[1];
    assign rdata3 = rdata_q[2];

endmodule : register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into pc on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 wenable  input  1  write strobe from write stage; one write per asserted cycle.
REQ-005 fmode  input  1  write target select: 0 integer file, 1 float file.
REQ-006 wreg  input  5  write register index.
REQ-007 wdata  input  32  write data.
REQ-008 pcenable  input  1  pc load strobe.
REQ-009 next_pc  input  32  pc value to load.
REQ-010 pc  output  32  current program counter.
REQ-011 enable  input  1  read request strobe from decode stage.
REQ-012 rs1, rs2, rs3  input  5 each  read register indices.
REQ-013 rs_fmode  input  3  per-operand file select; bit i-1 selects float file for rsi.
REQ-014 done  output  1  one-cycle pulse: read results valid.
REQ-015 rdata1, rdata2, rdata3  output  32 each  read results.

Function
REQ-016 Storage: 32x32 integer bank, 32x32 float bank.
REQ-017 Write: wenable high at edge N stores wdata into bank[fmode][wreg]; visible to reads accepted at edge N+1 onward.
REQ-018 Integer x0 reads 0 always; writes to integer x0 discarded; float f0 is an ordinary register.
REQ-019 pcenable high at edge N sets pc=next_pc after edge N; otherwise pc holds.
REQ-020 Read FSM, states IDLE and RESP: enable sampled high at edge N -> RESP, rdata1..3 registered, done=1 during cycle N+1.
REQ-021 From RESP: enable high -> stay RESP with new data, done stays 1 (back-to-back, one result per cycle); enable low -> IDLE, done=0.
REQ-022 rdata1..3 hold last result until the next accepted read; done never high in IDLE.
REQ-023 Read latency fixed at 1 cycle, no stall; writes, pc loads, reads are independent and may coincide in one cycle.
REQ-024 Same-cycle write and read of the same file/index: result per REQ-031/REQ-032.
REQ-025 Two operands naming the same register return identical values.

Reset
REQ-026 rst high at an edge: all registers of both banks=0, pc=RESET_PC, done=0, rdata1..3=0, FSM=IDLE.
REQ-027 Reset wins over same-cycle wenable, pcenable, enable; those requests are discarded.
REQ-028 Reset mid-operation (RESP): done=0 on the next cycle; no result issued for the pending request.
REQ-029 First request accepted at the first edge with rst low.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN compiles write-to-read forwarding in or out.
REQ-031 Defined: read accepted at edge N whose operand matches a same-cycle write (same file, same index, not integer x0) returns wdata.
REQ-032 Undefined: such a read returns the pre-write value; the write still commits.

Structure
REQ-033 Shared package core_pkg: XLEN=32, REG_IDX_W=5, NUM_REGS=32, read FSM state enum, reg_word typedef.
REQ-034 One sub-module regbank (32x32 array, 1 write port, 3 async read ports, parameter ZERO_R0), instantiated twice: integer with ZERO_R0=1, float with ZERO_R0=0.

Verification
REQ-035 Write x5=32'hDEAD_BEEF, next cycle read rs1=5 int -> done pulse next cycle, rdata1=32'hDEAD_BEEF.
REQ-036 Write int x0=32'h1234 and float f0=32'h3F80_0000; read rs1=0 int, rs2=0 float -> rdata1=0, rdata2=32'h3F80_0000.
REQ-037 Same-cycle write x7=32'hA5A5 (old 32'h1) and read rs1=7 -> rdata1=32'hA5A5 with REGFILE_BYPASS_EN, 32'h1 without; next read 32'hA5A5 either way.
REQ-038 enable high 3 consecutive cycles reading x1,x2,x3 (values 1,2,3) -> done high 3 consecutive cycles, rdata1=1,2,3 in order, then done=0.
REQ-039 pcenable with next_pc=32'h0000_0100 -> pc=32'h100 next cycle; rst with RESET_PC=32'h0 -> pc=0, all regs read 0.
REQ-040 enable then rst asserted next cycle -> done=0 the cycle after rst, rdata1..3=0.
